// File: rtl/screen_pkg.sv
// Shared types, tile codes and tile maps for the screen sequencer.
// Maps are indexed [map_row][map_col]; codes 0/1 are border/sky.
package screen_pkg;

  typedef enum logic [1:0] {
    SCR_START   = 2'd0,
    SCR_PLAYING = 2'd1,
    SCR_OVER    = 2'd2,
    SCR_WIN     = 2'd3
  } screen_t;

  localparam logic [7:0] BDR_TILE = 8'd0;
  localparam logic [7:0] SKY_TILE = 8'd1;

  localparam int MAP_ROWS_P = 12;
  localparam int MAP_COLS_P = 16;
  localparam int ROW_W = 4;
  localparam int COL_W = 4;

  typedef logic [7:0] map_t [0:MAP_ROWS_P-1][0:MAP_COLS_P-1];

  localparam map_t START_MAP = '{
    '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0},
    '{0,1,16,17,18,19,20,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,2,2,2,2,2,2,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,32,33,34,35,36,37,1,1,1,1,1,0},
    '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}
  };

  localparam map_t OVER_MAP = '{
    '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0},
    '{0,1,48,49,50,51,52,53,54,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,3,3,3,3,1,1,1,1,1,0},
    '{0,1,1,1,1,1,3,3,3,3,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,32,33,34,35,36,37,1,1,1,1,1,0},
    '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}
  };

  localparam map_t WIN_MAP = '{
    '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0},
    '{0,1,64,65,66,67,68,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,4,4,4,4,4,4,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0},
    '{0,1,1,1,32,33,34,35,36,37,1,1,1,1,1,0},
    '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}
  };

endpackage

// File: rtl/screen_tile_rom.sv
// Combinational tile-map lookup for the non-gameplay screens.
// Out-of-range indices and the PLAYING screen read as border.
module screen_tile_rom
  import screen_pkg::*;
#(
  parameter logic [7:0] BDR = BDR_TILE
) (
  input  screen_t    scr,
  input  int         map_row,
  input  int         map_col,
  output logic [7:0] tile
);

  logic [ROW_W-1:0] r_idx;
  logic [COL_W-1:0] c_idx;
  logic             in_range;

  // Select the map for this screen when the index is inside it
  always_comb begin
    r_idx = map_row[ROW_W-1:0];
    c_idx = map_col[COL_W-1:0];
    in_range = (map_row >= 0) && (map_row < MAP_ROWS_P)
            && (map_col >= 0) && (map_col < MAP_COLS_P);
    tile = BDR;
    if (in_range) begin
      unique case (scr)
        SCR_START: tile = START_MAP[r_idx][c_idx];
        SCR_OVER:  tile = OVER_MAP[r_idx][c_idx];
        SCR_WIN:   tile = WIN_MAP[r_idx][c_idx];
        default:   tile = BDR;
      endcase
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Screen-flow FSM with debounced jump input, blink and hold
// counters, and a registered per-pixel tile output.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter logic [7:0] BDR = 8'd0,
  parameter logic [7:0] SKY = 8'd1,
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int BLOCK_WIDTH     = 40,
  parameter int MAP_COLS        = 16,
  parameter int MAP_ROWS        = 12,
  parameter int PROMPT_ROW      = 10,
  parameter int BLINK_FRAMES    = 30,
  parameter int HOLD_FRAMES     = 60,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       vga_clock,
  input  logic       reset,
  input  logic       jump_button,
  input  logic       game_over,
  input  logic       game_won,
  input  int         row,
  input  int         column,
  input  logic       display_enable,
  output logic [7:0] tile,
  output logic [1:0] screen_id,
  output logic       screen_active,
  output logic       game_start
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BKW = $clog2(BLINK_FRAMES + 1);
  localparam int HDW =
    (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BKW-1:0] BK_MAX = BKW'(BLINK_FRAMES - 1);
  localparam logic [HDW-1:0] HD_MAX = HDW'(HOLD_FRAMES);

  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic           deb_q, deb_d;
  logic           deb_dly_q, deb_dly_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [BKW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_on_q, blink_on_d;
  logic [HDW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]     tile_q, tile_d;
  screen_t        state_q, state_d;
  logic           game_start_q, game_start_d;

  logic       press;
  logic       frame_tick;
  logic       entry;
  int         map_row;
  int         map_col;
  logic [7:0] rom_tile;

  assign map_row = row / BLOCK_WIDTH;
  assign map_col = column / BLOCK_WIDTH;

  assign frame_tick = display_enable
                   && (row == SCREEN_HEIGHT - 1)
                   && (column == SCREEN_WIDTH - 1);

  assign press = deb_q & ~deb_dly_q;
  assign entry = (state_d != state_q);

  screen_tile_rom #(
    .BDR (BDR)
  ) u_rom (
    .scr     (state_q),
    .map_row (map_row),
    .map_col (map_col),
    .tile    (rom_tile)
  );

  // Synchronise the button and accept a level once it holds steady
  always_comb begin
    sync1_d   = jump_button;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    db_cnt_d  = '0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_MAX) deb_d = sync2_q;
      else db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Blink and hold counters restart whenever a screen is entered
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    hold_cnt_d  = hold_cnt_q;
    if (entry) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
      hold_cnt_d  = '0;
    end else if (frame_tick) begin
      if (blink_cnt_q == BK_MAX) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
      if (hold_cnt_q != HD_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // Pixel tile: border outside maps and during gameplay
  always_comb begin
    tile_d = BDR;
    if (display_enable && (row >= 0) && (column >= 0)
        && (map_row < MAP_ROWS) && (map_col < MAP_COLS)
        && (state_q != SCR_PLAYING)) begin
      if ((map_row == PROMPT_ROW) && !blink_on_q) tile_d = SKY;
      else tile_d = rom_tile;
    end
  end

  // Next screen from presses and game-logic events
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCR_START: if (press) state_d = SCR_PLAYING;
      SCR_PLAYING: begin
        if (game_won) state_d = SCR_WIN;
        else if (game_over) state_d = SCR_OVER;
      end
      SCR_OVER, SCR_WIN: begin
        if (press && (hold_cnt_q == HD_MAX)) state_d = SCR_START;
      end
      default: state_d = SCR_START;
    endcase
  end

  // Screen outputs and the start pulse on leaving START
  always_comb begin
    screen_id     = state_q;
    screen_active = (state_q != SCR_PLAYING);
    game_start_d  = (state_q == SCR_START)
                 && (state_d == SCR_PLAYING);
  end

  // Screen state register
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state_q      <= SCR_START;
      game_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      game_start_q <= game_start_d;
    end
  end

  // Input conditioning, counters and tile register
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_q       <= 1'b0;
      deb_dly_q   <= 1'b0;
      db_cnt_q    <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      hold_cnt_q  <= '0;
      tile_q      <= BDR;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_dly_q   <= deb_dly_d;
      db_cnt_q    <= db_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      hold_cnt_q  <= hold_cnt_d;
      tile_q      <= tile_d;
    end
  end

  assign tile       = tile_q;
  assign game_start = game_start_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with short debounce,
// blink and hold settings; expected values are hand-computed.
module tb_screen_sequencer;

  logic       vga_clock = 1'b0;
  logic       reset = 1'b1;
  logic       jump_button = 1'b0;
  logic       game_over = 1'b0;
  logic       game_won = 1'b0;
  int         row = 0;
  int         column = 0;
  logic       display_enable = 1'b0;
  logic [7:0] tile;
  logic [1:0] screen_id;
  logic       screen_active;
  logic       game_start;

  int checks = 0;
  int failures = 0;
  int gs_cnt = 0;

  always #5 vga_clock = ~vga_clock;

  always @(negedge vga_clock) if (game_start) gs_cnt++;

  screen_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .BLINK_FRAMES    (2),
    .HOLD_FRAMES     (3)
  ) dut (
    .vga_clock      (vga_clock),
    .reset          (reset),
    .jump_button    (jump_button),
    .game_over      (game_over),
    .game_won       (game_won),
    .row            (row),
    .column         (column),
    .display_enable (display_enable),
    .tile           (tile),
    .screen_id      (screen_id),
    .screen_active  (screen_active),
    .game_start     (game_start)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge vga_clock);
      #1;
    end
  endtask

  task automatic pix(input int r, input int c);
    row = r;
    column = c;
    display_enable = 1'b1;
    step();
    display_enable = 1'b0;
  endtask

  task automatic tick();
    row = 479;
    column = 639;
    display_enable = 1'b1;
    step();
    display_enable = 1'b0;
    row = 0;
    column = 0;
  endtask

  task automatic press();
    jump_button = 1'b1;
    step(8);
    jump_button = 1'b0;
    step(8);
  endtask

  initial begin
    step(3);
    check("rst_tile", tile, 0);
    check("rst_id", screen_id, 0);
    check("rst_active", screen_active, 1);
    check("rst_gs", game_start, 0);
    reset = 1'b0;

    pix(40, 80);
    check("start_1_2", tile, 16);
    step();
    check("de_low", tile, 0);
    pix(40, 640);
    check("oob_col", tile, 0);
    pix(80, 40);
    check("start_2_1", tile, 1);

    pix(400, 160);
    check("blink_f0", tile, 32);
    tick();
    pix(400, 160);
    check("blink_f1", tile, 32);
    tick();
    pix(400, 160);
    check("blink_f2", tile, 1);
    tick();
    pix(400, 160);
    check("blink_f3", tile, 1);
    tick();
    pix(400, 160);
    check("blink_f4", tile, 32);

    jump_button = 1'b1;
    step(3);
    jump_button = 1'b0;
    step(10);
    check("glitch_id", screen_id, 0);
    check("glitch_gs", gs_cnt, 0);

    jump_button = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 5) check("press_lat", screen_id, 0);
      if (i == 6) begin
        check("press_gs", game_start, 1);
        check("press_id", screen_id, 1);
      end
      if (i == 7) check("press_gs_end", game_start, 0);
    end
    jump_button = 1'b0;
    step(10);
    check("press_cnt", gs_cnt, 1);
    check("play_active", screen_active, 0);

    pix(40, 80);
    check("play_1_2", tile, 0);
    pix(400, 160);
    check("play_prompt", tile, 0);
    pix(80, 40);
    check("play_2_1", tile, 0);
    tick();
    pix(40, 80);
    check("play_next", tile, 0);

    press();
    check("play_press_id", screen_id, 1);
    check("play_press_gs", gs_cnt, 1);

    game_over = 1'b1;
    game_won = 1'b1;
    step();
    game_over = 1'b0;
    game_won = 1'b0;
    check("both_win", screen_id, 3);
    check("win_active", screen_active, 1);
    pix(40, 80);
    check("win_1_2", tile, 64);
    pix(400, 160);
    check("win_prompt", tile, 32);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    check("win_ign_over", screen_id, 3);

    tick();
    tick();
    tick();
    press();
    check("win_exit", screen_id, 0);
    check("win_exit_gs", gs_cnt, 1);

    press();
    check("restart_id", screen_id, 1);
    check("restart_gs", gs_cnt, 2);

    game_over = 1'b1;
    step();
    game_over = 1'b0;
    check("over_entry", screen_id, 2);
    pix(40, 80);
    check("over_1_2", tile, 48);
    tick();
    tick();
    press();
    check("hold_early", screen_id, 2);
    tick();
    press();
    check("hold_done", screen_id, 0);
    check("hold_no_gs", gs_cnt, 2);

    jump_button = 1'b1;
    step(4);
    reset = 1'b1;
    step();
    check("rst_mid_id", screen_id, 0);
    check("rst_mid_gs", game_start, 0);
    reset = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (j == 5) begin
        check("rst_lat_id", screen_id, 0);
        check("rst_lat_gs", game_start, 0);
      end
      if (j == 6) begin
        check("rst_press_gs", game_start, 1);
        check("rst_press_id", screen_id, 1);
      end
    end
    jump_button = 1'b0;
    step(10);
    check("rst_press_cnt", gs_cnt, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Parametrised multi-screen tile generator with a screen-flow state machine. It replaces the single static start-screen drawer: it holds start, game-over and win tile maps, and advances between them on a debounced jump press and on game-logic events. The prompt row blinks at a frame-counted rate. The block feeds a per-pixel tile code to the VGA interface and tells the top level when gameplay owns the display.

## Interface
- BDR, 0: border/text tile code
- SKY, 1: sky tile code
- SCREEN_WIDTH, 640: visible pixels per line
- SCREEN_HEIGHT, 480: visible lines
- BLOCK_WIDTH, 40: tile edge in pixels
- MAP_COLS, 16: tile columns (SCREEN_WIDTH/BLOCK_WIDTH)
- MAP_ROWS, 12: tile rows (SCREEN_HEIGHT/BLOCK_WIDTH)
- PROMPT_ROW, 10: map row that blinks
- BLINK_FRAMES, 30: frames per blink half-period, ≥1
- HOLD_FRAMES, 60: minimum frames on game-over/win before a press is accepted
- DEBOUNCE_CYCLES, 250000: stable cycles required on jump_button, ≥1
- vga_clock  in  1  pixel clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- jump_button  in  1  raw asynchronous button, active-high
- game_over  in  1  one-cycle pulse from game logic
- game_won  in  1  one-cycle pulse from game logic
- row  in  int  current visible line
- column  in  int  current visible pixel
- display_enable  in  1  high in the visible region
- tile  out  8  tile code for (row, column), registered
- screen_id  out  2  0=START, 1=PLAYING, 2=OVER, 3=WIN
- screen_active  out  1  high when this block owns the display (not PLAYING)
- game_start  out  1  one-cycle pulse when leaving START

## Operation
- Input conditioning: two-flop synchroniser on jump_button. The debounced level follows the synchronised level only after that level has been stable for DEBOUNCE_CYCLES consecutive cycles. A press is a debounced 0→1 edge, one cycle wide.
- frame_tick: one cycle when display_enable && row==SCREEN_HEIGHT-1 && column==SCREEN_WIDTH-1.
- FSM states:
  - START: a press moves to PLAYING and pulses game_start.
  - PLAYING: presses are ignored. game_won moves to WIN; game_over moves to OVER. If both pulse in the same cycle, WIN wins.
  - OVER / WIN: on entry, hold_cnt is cleared. hold_cnt counts frame_ticks, saturating at HOLD_FRAMES. A press with hold_cnt==HOLD_FRAMES moves to START; earlier presses are dropped.
  - game_over/game_won outside PLAYING are ignored.
- Blink: blink_cnt counts frame_ticks 0..BLINK_FRAMES-1 and wraps. blink_on toggles on each wrap. blink_cnt is cleared and blink_on set to 1 on every state entry.
- Tile lookup:
  - map_col = column/BLOCK_WIDTH and map_row = row/BLOCK_WIDTH, constant-divisor division.
  - tile = ROM(screen_id, map_row, map_col).
  - If map_row==PROMPT_ROW && !blink_on, the tile is forced to SKY (prompt hidden).
  - BDR is output whenever any of the following holds: display_enable low, map index out of range, or state PLAYING.
- Reset values: state START, tile=BDR, screen_id=0, screen_active=1, game_start=0, blink_on=1, all counters 0, debounced level 0.

## Timing
- tile has 1-cycle latency: the value presented at cycle t+1 corresponds to row/column/display_enable at cycle t.
- Press latency: the synchronised level reaches the debouncer 2 cycles after the raw edge. Debounced level rises DEBOUNCE_CYCLES cycles later; the FSM transitions on the next edge.
- screen_id, screen_active and game_start update in the same cycle as the state register. game_start is high for exactly one cycle.
- A raw glitch shorter than DEBOUNCE_CYCLES never produces a press.
- Holding the button produces only one press; the button must be released (debounced) before another press.
- Reset mid-transition or mid-debounce returns to the full reset state on the next edge; no game_start is emitted.

## Structure
- Package screen_pkg holds:
  - screen_t enum (START, PLAYING, OVER, WIN).
  - Default tile constants.
  - The three MAP_ROWS×MAP_COLS map literals.
- Sub-module screen_tile_rom: combinational map lookup indexed by screen_t, map_row and map_col. It returns BDR for out-of-range indices and for PLAYING.
- The top-level module contains the synchroniser, debouncer, frame/blink/hold counters, FSM and output register.

## Test plan
Benches run with DEBOUNCE_CYCLES=4, BLINK_FRAMES=2, HOLD_FRAMES=3 unless noted.
- Reset check: assert reset 3 cycles → tile=0, screen_id=0, screen_active=1, game_start=0. Drive row=40, column=80 with display_enable=1 → next cycle tile = START map[1][2].
- Debounce: 3-cycle button pulse → no transition. 10-cycle pulse → exactly one game_start pulse, screen_id=1, tile=BDR for the whole next frame.
- Simultaneous events in PLAYING: game_over and game_won on the same cycle → screen_id=3.
- Hold gate: in OVER, press after 2 frame_ticks → stays in OVER. Press after 3 frame_ticks → screen_id=0, game_start stays 0.
- Blink: in START, pixels on PROMPT_ROW show map tiles in frames 0-1, SKY in frames 2-3, map tiles again in frame 4.
- Mid-debounce reset: button high, reset asserted at debounce count 2, button held → after reset, a press requires a full 2+4 stable cycles before game_start.
